fetch: RTL



---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_hold_buf.sv | 43 ++++
 rtl/fetch.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_ENC = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {PC, instruction} skid register; captures a response while decode stalls.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t data_o,
    output logic         valid_o
);

    logic         valid_q, valid_d;
    fetch_entry_t data_q, data_d;

    // Load wins over clear: the entry can drain and refill in the same cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory, fills the IF/ID register.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_ENC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_Stall,
    input  logic        i_Redirect,
    input  logic [31:0] i_RedirectPC,
    output logic        o_imem_ReqValid,
    output logic [31:0] o_imem_Addr,
    input  logic        i_imem_ReqReady,
    input  logic        i_imem_RspValid,
    input  logic [31:0] i_imem_RspData,
    output logic [31:0] o_pipe_PC,
    output logic [31:0] o_pipe_Instruction,
    output logic        o_pipe_Valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    fetch_entry_t pipe_q, pipe_d;
    logic         pipe_valid_q, pipe_valid_d;

    logic         hold_load, hold_clear, hold_valid;
    fetch_entry_t hold_data, rsp_entry;
    logic         req_valid, req_fire, rsp_take;

    // pc_q already advanced past the outstanding request when it was accepted.
    assign rsp_entry.pc   = pc_q - 32'd4;
    assign rsp_entry.inst = i_imem_RspData;

    assign rsp_take = i_imem_RspValid && (state_q == S_WAIT) && !i_Redirect;
    assign req_fire = o_imem_ReqValid && i_imem_ReqReady;

    fetch_hold_buf u_hold (
        .clk     (clk),
        .reset   (reset),
        .load_i  (hold_load),
        .clear_i (hold_clear),
        .data_i  (rsp_entry),
        .data_o  (hold_data),
        .valid_o (hold_valid)
    );

    always_comb begin
        req_valid = 1'b0;
        unique case (state_q)
            S_REQ:   req_valid = !hold_valid;
            S_WAIT:  req_valid = i_imem_RspValid && !i_Stall && !hold_valid;
            default: req_valid = 1'b0;
        endcase
        if (i_Redirect || reset) begin
            req_valid = 1'b0;
        end
    end

    assign o_imem_ReqValid = req_valid;
    assign o_imem_Addr     = pc_q;

    always_comb begin
        pipe_d       = pipe_q;
        pipe_valid_d = pipe_valid_q;
        hold_load    = 1'b0;
        hold_clear   = 1'b0;
        if (i_Redirect) begin
            pipe_d.inst  = NOP_INST;
            pipe_valid_d = 1'b0;
            hold_clear   = 1'b1;
        end else if (!i_Stall) begin
            if (hold_valid) begin
                pipe_d       = hold_data;
                pipe_valid_d = 1'b1;
                hold_clear   = 1'b1;
                hold_load    = rsp_take;
            end else if (rsp_take) begin
                pipe_d       = rsp_entry;
                pipe_valid_d = 1'b1;
            end else begin
                pipe_d.inst  = NOP_INST;
                pipe_valid_d = 1'b0;
            end
        end else begin
            hold_load = rsp_take;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
        unique case (state_q)
            S_REQ:  if (req_fire) state_d = S_WAIT;
            S_WAIT: if (i_imem_RspValid) state_d = req_fire ? S_WAIT : S_REQ;
            S_DROP: if (i_imem_RspValid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
        if (i_Redirect) begin
            pc_d = align_word(i_RedirectPC);
            if ((state_q == S_WAIT || state_q == S_DROP) && !i_imem_RspValid) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= align_word(RESET_PC);
            pipe_q.pc    <= '0;
            pipe_q.inst  <= NOP_INST;
            pipe_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pipe_q       <= pipe_d;
            pipe_valid_q <= pipe_valid_d;
        end
    end

    assign o_pipe_PC          = pipe_q.pc;
    assign o_pipe_Instruction = pipe_q.inst;
    assign o_pipe_Valid       = pipe_valid_q;

    a_no_rsp_in_req: assert property (@(posedge clk) disable iff (reset)
        !(i_imem_RspValid && state_q == S_REQ));

    a_hold_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(hold_load && hold_valid && !hold_clear));

endmodule
